// File: rtl/data_mem_responder.sv
// data_mem_responder: M-stage data port responder with programmable wait states.
// Ports: clk/reset, req/we/addr/wdata/byteEnable in; rdata/stall/ready/err out.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byteEnable,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  wcnt;
  logic        q_we;
  logic [31:0] q_addr;
  logic [31:0] q_wdata;
  logic [3:0]  q_be;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          a_we;
  logic [31:0]   a_addr;
  logic [31:0]   a_wdata;
  logic [3:0]    a_be;
  logic          range_err;
  logic          align_err;
  logic          a_err;
  logic          go_done;
  logic [AW-1:0] idx;

  // With zero wait states the access happens on the same edge that
  // latches the request, so the live inputs must be used then.
  always_comb begin
    a_we    = q_we;
    a_addr  = q_addr;
    a_wdata = q_wdata;
    a_be    = q_be;
    if (state == IDLE) begin
      a_we    = we;
      a_addr  = addr;
      a_wdata = wdata;
      a_be    = byteEnable;
    end
    range_err = (a_addr[31:2] >= 30'(DEPTH_WORDS));
    align_err = a_we && (a_be == 4'hF) && (a_addr[1:0] != 2'b00);
    a_err     = range_err || align_err;
    idx       = a_addr[AW+1:2];
    go_done   = ((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                ((state == BUSY) && (wcnt == 4'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wcnt    <= 4'd0;
      rdata   <= 32'd0;
      err_q   <= 1'b0;
      q_we    <= 1'b0;
      q_addr  <= 32'd0;
      q_wdata <= 32'd0;
      q_be    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            q_we    <= we;
            q_addr  <= addr;
            q_wdata <= wdata;
            q_be    <= byteEnable;
            if (WAIT_CYCLES == 0) begin
              state <= DONE;
            end else begin
              wcnt  <= 4'(WAIT_CYCLES - 1);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (wcnt == 4'd0) state <= DONE;
          else wcnt <= wcnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (go_done) begin
        err_q <= a_err;
        if (a_err) rdata <= 32'd0;
        else if (!a_we) rdata <= mem[idx];
      end
    end
  end

  // No reset on the array; a store caught by reset is simply dropped.
  always_ff @(posedge clk) begin
    if (!reset && go_done && a_we && !a_err) begin
      for (int i = 0; i < 4; i++) begin
        if (a_be[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
      end
    end
  end

  assign stall = ((state == IDLE) && req) || (state == BUSY);
  assign ready = (state == DONE);
  assign err   = ready && err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: table + scoreboard bench for data_mem_responder.
// Drives a WAIT=2 instance for most cases and a WAIT=0 one for back-to-back.
module tb_data_mem_responder;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        chk;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req2 = 1'b0, we2 = 1'b0;
  logic [31:0] addr2 = '0, wdata2 = '0;
  logic [3:0]  be2 = '0;
  logic [31:0] rdata2;
  logic        stall2, ready2, err2;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic [3:0]  be0 = '0;
  logic [31:0] rdata0;
  logic        stall0, ready0, err0;

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .req(req2), .we(we2), .addr(addr2),
    .wdata(wdata2), .byteEnable(be2), .rdata(rdata2), .stall(stall2),
    .ready(ready2), .err(err2)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0),
    .wdata(wdata0), .byteEnable(be0), .rdata(rdata0), .stall(stall0),
    .ready(ready0), .err(err0)
  );

  int nvec = 0;
  int nmis = 0;
  vec_t sb[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ready2) begin
      if (sb.size() == 0) begin
        chk("spurious_ready", 32'(ready2), 32'd0);
      end else begin
        vec_t v;
        v = sb.pop_front();
        chk("err", 32'(err2), 32'(v.exp_err));
        if (v.chk) chk("rdata", rdata2, v.exp_rdata);
      end
    end else if (err2) begin
      chk("err_without_ready", 32'(err2), 32'd0);
    end
  end

  // Called at negedge+1; returns at negedge+1 of the idle cycle after DONE.
  task automatic do_access(input vec_t v);
    int n;
    sb.push_back(v);
    we2 = v.we; addr2 = v.addr; wdata2 = v.wdata; be2 = v.be;
    req2 = 1'b1;
    #1;
    n = 0;
    while (!ready2 && n < 20) begin
      chk("stall_busy", 32'(stall2), 32'd1);
      @(negedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'd3);
    chk("stall_done", 32'(stall2), 32'd0);
    req2 = 1'b0;
    @(negedge clk); #1;
    chk("ready_after", 32'(ready2), 32'd0);
  endtask

  vec_t tbl[11];
  int rdy_cnt;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0, 1'b1};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 32'h10,  32'h0000AA00, 4'h2, 32'hDEADBEEF, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADAAEF, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 32'h400, 32'h55555555, 4'hF, 32'h0,        1'b1, 1'b0};
    tbl[5]  = '{1'b0, 32'h400, 32'h0,        4'h0, 32'h0,        1'b1, 1'b1};
    tbl[6]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADAAEF, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 32'h12,  32'h12345678, 4'hF, 32'h0,        1'b1, 1'b0};
    tbl[8]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADAAEF, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 32'h20,  32'h11111111, 4'hF, 32'hDEADAAEF, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 32'h20,  32'h0,        4'h0, 32'h11111111, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    @(negedge clk); #1;
    chk("rst_rdata", rdata2, 32'd0);
    chk("rst_stall", 32'(stall2), 32'd0);
    chk("rst_ready", 32'(ready2), 32'd0);
    chk("rst_err", 32'(err2), 32'd0);

    foreach (tbl[i]) do_access(tbl[i]);

    we2 = 1'b1; addr2 = 32'h20; wdata2 = 32'hCAFEF00D; be2 = 4'hF;
    req2 = 1'b1;
    @(negedge clk); #1;
    chk("busy_stall", 32'(stall2), 32'd1);
    reset = 1'b1;
    req2 = 1'b0;
    @(negedge clk); #1;
    reset = 1'b0;
    chk("rst_mid_stall", 32'(stall2), 32'd0);
    chk("rst_mid_ready", 32'(ready2), 32'd0);
    chk("rst_mid_rdata", rdata2, 32'd0);
    repeat (3) @(negedge clk);
    #1;
    do_access('{1'b0, 32'h20, 32'h0, 4'h0, 32'h11111111, 1'b0, 1'b1});
    do_access('{1'b1, 32'h23, 32'hAB000000, 4'h8, 32'h11111111, 1'b0, 1'b1});
    do_access('{1'b0, 32'h20, 32'h0, 4'h0, 32'hAB111111, 1'b0, 1'b1});

    we0 = 1'b1; addr0 = 32'h4; wdata0 = 32'hA5A5A5A5; be0 = 4'hF;
    req0 = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("w0_stall", 32'(stall0), 32'((i % 2) == 0));
      chk("w0_ready", 32'(ready0), 32'((i % 2) == 1));
      if (ready0) rdy_cnt++;
      if (i == 3) req0 = 1'b0;
      @(negedge clk);
    end
    #1;
    chk("w0_idle_stall", 32'(stall0), 32'd0);
    chk("w0_idle_ready", 32'(ready0), 32'd0);
    chk("w0_ready_count", 32'(rdy_cnt), 32'd2);
    we0 = 1'b0; req0 = 1'b1;
    #1;
    chk("w0_ld_stall", 32'(stall0), 32'd1);
    @(negedge clk); #1;
    req0 = 1'b0;
    chk("w0_ld_ready", 32'(ready0), 32'd1);
    chk("w0_ld_rdata", rdata0, 32'hA5A5A5A5);
    chk("w0_ld_err", 32'(err0), 32'd0);

    repeat (2) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
